cordic_hyp_seq: RTL

Iteration sequencer for the hyperbolic CORDIC datapath. It accepts one operand set per valid/ready handshake and pulses the datapath load enable. It then drives one micro-rotation per cycle with the shift index, inserting the mandatory hyperbolic repeat iterations (indices 4 and 13). It presents completion via a valid/ready output handshake. The block holds no data: the x/y/z registers and the adders stay in the datapath.

---
 rtl/cordic_hyp_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cordic_hyp_seq.sv
// Iteration sequencer for the hyperbolic CORDIC datapath.
// Accepts one operand set per in_valid/in_ready handshake, pulses ld_en,
// then issues one micro-rotation per cycle with the shift index. Indices
// REP1 and REP2 are executed twice. Completion uses out_valid/out_ready.
// The x/y/z registers and adders live in the datapath, not here.
//
// Optional build macro: CORDIC_HYP_SEQ_ABORT_EN adds an abort input that
// cancels any operation and beats a simultaneous accept.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an operand set, in_ready=1
// S_ITER | one micro-rotation per cycle, step_en=1
// S_DONE | result final, out_valid=1 until out_ready
module cordic_hyp_seq #(
    parameter int N_ITER = 12,
    parameter int IW     = 4,
    parameter int REP1   = 4,
    parameter int REP2   = 13,
    parameter int SCW    = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           ld_en,
    output logic           step_en,
    output logic [IW-1:0]  shift,
    output logic [SCW-1:0] step_cnt,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready
`ifdef CORDIC_HYP_SEQ_ABORT_EN
    ,
    input  logic           abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    localparam logic [IW-1:0] LAST    = IW'(N_ITER);
    localparam logic [IW-1:0] REP1_I  = IW'(REP1);
    localparam logic [IW-1:0] REP2_I  = IW'(REP2);
    // A repeat index beyond the last index is never reached; masking it
    // also keeps a truncated value from aliasing onto a real index.
    localparam bit            REP1_ON = (REP1 <= N_ITER);
    localparam bit            REP2_ON = (REP2 <= N_ITER);

    state_t         state, state_nxt;
    logic [IW-1:0]  shift_nxt;
    logic [SCW-1:0] cnt_nxt;
    logic           rep_flag, rep_nxt;
    logic           is_rep;
    logic           abort_i;

`ifdef CORDIC_HYP_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign is_rep = (REP1_ON && (shift == REP1_I)) || (REP2_ON && (shift == REP2_I));
    assign busy   = (state != S_IDLE);

    // Next-state, index selection and handshake outputs.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = step_cnt;
        rep_nxt   = rep_flag;
        in_ready  = 1'b0;
        ld_en     = 1'b0;
        step_en   = 1'b0;
        out_valid = 1'b0;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_ITER: begin
                step_en = 1'b1;
                cnt_nxt = step_cnt + SCW'(1);
                if (is_rep && !rep_flag) begin
                    rep_nxt = 1'b1;
                end else if (shift == LAST) begin
                    rep_nxt   = 1'b0;
                    state_nxt = S_DONE;
                end else begin
                    rep_nxt   = 1'b0;
                    shift_nxt = shift + IW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) begin
                    state_nxt = S_IDLE;
                    shift_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                shift_nxt = '0;
                cnt_nxt   = '0;
                rep_nxt   = 1'b0;
            end
        endcase

        ld_en = in_valid && in_ready;
        if (ld_en) begin
            state_nxt = S_ITER;
            shift_nxt = IW'(1);
            cnt_nxt   = '0;
            rep_nxt   = 1'b0;
        end

        if (abort_i) begin
            in_ready  = 1'b0;
            ld_en     = 1'b0;
            step_en   = 1'b0;
            out_valid = 1'b0;
            state_nxt = S_IDLE;
            shift_nxt = '0;
            cnt_nxt   = '0;
            rep_nxt   = 1'b0;
        end
    end

    // State, index, step counter and repeat flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            step_cnt <= '0;
            rep_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            step_cnt <= cnt_nxt;
            rep_flag <= rep_nxt;
        end
    end

endmodule
